// File: rtl/stack_arbiter.sv
// Round-robin two-port arbiter around a 4x4-bit stack, one operation per grant.
// Define STACK_ARB_FIXED_PRIO_EN to give requester A fixed priority on ties.
module stack_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [1:0] op_a,
  input  logic [3:0] din_a,
  input  logic       req_b,
  input  logic [1:0] op_b,
  input  logic [3:0] din_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       err,
  output logic [3:0] dout,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  state_t     state;
  logic [3:0] mem [4];
  logic       gnt_b;
  logic [1:0] op;
  logic [3:0] din;
  logic       pick_b;
  logic [1:0] top;

  assign top = count[1:0] - 2'd1;

`ifdef STACK_ARB_FIXED_PRIO_EN
  assign pick_b = !req_a;
`else
  logic last_b;
  // On a tie the requester that did not win last time gets the grant
  assign pick_b = req_b && (!req_a || !last_b);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      dout  <= '0;
      err   <= 1'b0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      busy  <= 1'b0;
      full  <= 1'b0;
      empty <= 1'b1;
      gnt_b <= 1'b0;
      op    <= '0;
      din   <= '0;
`ifndef STACK_ARB_FIXED_PRIO_EN
      last_b <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_a || req_b) begin
            gnt_b <= pick_b;
            op    <= pick_b ? op_b : op_a;
            din   <= pick_b ? din_b : din_a;
`ifndef STACK_ARB_FIXED_PRIO_EN
            last_b <= pick_b;
`endif
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          ack_a <= !gnt_b;
          ack_b <= gnt_b;
          err   <= 1'b0;
          state <= ACK;
          unique case (op)
            OP_PUSH: begin
              if (count != 3'd4) begin
                mem[count[1:0]] <= din;
                count <= count + 3'd1;
                full  <= (count == 3'd3);
                empty <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
            OP_POP: begin
              if (count != 3'd0) begin
                dout     <= mem[top];
                mem[top] <= '0;
                count    <= count - 3'd1;
                empty    <= (count == 3'd1);
                full     <= 1'b0;
              end else begin
                dout <= '0;
                err  <= 1'b1;
              end
            end
            OP_PEEK: begin
              if (count != 3'd0) begin
                dout <= mem[top];
              end else begin
                dout <= '0;
                err  <= 1'b1;
              end
            end
            OP_CLEAR: begin
              for (int i = 0; i < 4; i++) mem[i] <= '0;
              count <= '0;
              full  <= 1'b0;
              empty <= 1'b1;
            end
            default: ;
          endcase
        end
        ACK: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Randomized bench for stack_arbiter against a queue-based stack model.
// Honours STACK_ARB_FIXED_PRIO_EN in the reference arbitration.
module tb_stack_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] op_a, op_b;
  logic [3:0] din_a, din_b;
  logic       ack_a, ack_b, err, full, empty, busy;
  logic [3:0] dout;
  logic [2:0] count;

  int vecs = 0;
  int errs = 0;

  logic [3:0] stk [$];
  bit         last_b = 1'b1;

  stack_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .din_a(din_a),
    .req_b(req_b), .op_b(op_b), .din_b(din_b),
    .ack_a(ack_a), .ack_b(ack_b), .err(err), .dout(dout),
    .count(count), .full(full), .empty(empty), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_op(input logic [1:0] o, input logic [3:0] d,
                          output bit e, output logic [3:0] q);
    e = 1'b0;
    q = 4'h0;
    case (o)
      2'd0: if (stk.size() < 4) stk.push_back(d); else e = 1'b1;
      2'd1: if (stk.size() > 0) q = stk.pop_back(); else e = 1'b1;
      2'd2: if (stk.size() > 0) q = stk[$]; else e = 1'b1;
      default: stk.delete();
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stk.delete();
    last_b = 1'b1;
  endtask

  task automatic run(input bit ra, input bit rb,
                     input logic [1:0] oa, input logic [1:0] ob,
                     input logic [3:0] da, input logic [3:0] db);
    bit pa, pb, win_b, e;
    int lat, exp_lat;
    logic [1:0] o;
    logic [3:0] d, q;
    pa = ra;
    pb = rb;
    exp_lat = 2;
    req_a = ra; op_a = oa; din_a = da;
    req_b = rb; op_b = ob; din_b = db;
    while (pa || pb) begin
`ifdef STACK_ARB_FIXED_PRIO_EN
      win_b = !pa;
`else
      win_b = pb && (!pa || !last_b);
`endif
      last_b = win_b;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        // Operands are only sampled at the grant edge
        if (lat == exp_lat - 1) begin
          if (win_b) {op_b, din_b} = 6'($urandom);
          else       {op_a, din_a} = 6'($urandom);
        end
      end while (!(ack_a || ack_b) && lat < 8);
      chk("latency", lat, exp_lat);
      chk("ack_a", 32'(ack_a), 32'(!win_b));
      chk("ack_b", 32'(ack_b), 32'(win_b));
      if (!(ack_a || ack_b)) begin
        do_reset();
        return;
      end
      o = win_b ? ob : oa;
      d = win_b ? db : da;
      model_op(o, d, e, q);
      chk("err", 32'(err), 32'(e));
      if (o == 2'd1 || o == 2'd2) chk("dout", 32'(dout), 32'(q));
      chk("count", 32'(count), stk.size());
      chk("full", 32'(full), 32'(stk.size() == 4));
      chk("empty", 32'(empty), 32'(stk.size() == 0));
      chk("busy_ack", 32'(busy), 32'd1);
      if (win_b) pb = 1'b0; else pa = 1'b0;
      req_a = pa;
      req_b = pb;
      exp_lat = 3;
    end
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int r;
    logic [1:0] oa, ob;
    op_a = 2'd0; op_b = 2'd0; din_a = 4'h0; din_b = 4'h0;
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({ack_a, ack_b}), 32'd0);
    chk("rst_dout_err", 32'({dout, err}), 32'd0);

    run(1, 0, 2'd0, 2'd0, 4'h3, 4'h0);
    run(1, 0, 2'd0, 2'd0, 4'h5, 4'h0);
    run(1, 0, 2'd0, 2'd0, 4'h9, 4'h0);
    run(1, 0, 2'd0, 2'd0, 4'hC, 4'h0);
    run(0, 1, 2'd0, 2'd0, 4'h0, 4'h7);
    for (int i = 0; i < 4; i++) run(0, 1, 2'd0, 2'd1, 4'h0, 4'h0);
    run(1, 0, 2'd1, 2'd0, 4'h0, 4'h0);
    run(1, 0, 2'd2, 2'd0, 4'h0, 4'h0);

    do_reset();
    run(1, 1, 2'd0, 2'd0, 4'h1, 4'h2);
    run(1, 1, 2'd0, 2'd0, 4'h1, 4'h2);
    for (int i = 0; i < 4; i++) run(1, 0, 2'd1, 2'd0, 4'h0, 4'h0);

    run(0, 1, 2'd0, 2'd0, 4'h0, 4'hF);
    run(1, 0, 2'd2, 2'd0, 4'h0, 4'h0);
    run(0, 1, 2'd3, 2'd3, 4'h0, 4'h0);
    run(1, 0, 2'd2, 2'd0, 4'h0, 4'h0);

    run(1, 0, 2'd0, 2'd0, 4'h6, 4'h0);
    req_a = 1'b1; op_a = 2'd0; din_a = 4'hA;
    @(negedge clk);
    rst = 1'b1;
    req_a = 1'b0;
    @(negedge clk);
    chk("midrst_ack", 32'({ack_a, ack_b}), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    stk.delete();
    last_b = 1'b1;
    @(negedge clk);
    run(1, 0, 2'd1, 2'd0, 4'h0, 4'h0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      oa = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 9);
      ob = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 2);
      run(r != 1, r != 0, oa, ob, 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
